fa_setpoint: RTL and testbench
==============================

# fa_setpoint

Parametrised frequency/amplitude setpoint unit for the rocking controller. It holds the frequency setpoint F and amplitude setpoint A in saturating up/down registers, with bounded ranges and a synchronous load. An optional auto-decay mode lowers A at a programmable rate, and a small state machine reports when rocking has stopped. It sits between the button/command decoder and the motor drive, and supersedes the fixed 3-bit F/A counter pair.

## Interface
- W, 3: width of F and A.
- F_INIT, 5: F value after reset.
- A_INIT, 5: A value after reset.
- F_MIN, 0: lower saturation bound of F.
- F_MAX, 7: upper saturation bound of F.
- A_MAX, 7: upper saturation bound of A; the lower bound is 0.
- DECAY_DIV, 16: clock cycles between auto-decay decrements; must be ≥1.
- Legal parameter set: F_MIN ≤ F_INIT ≤ F_MAX < 2^W and A_INIT ≤ A_MAX < 2^W. Prescaler width is $clog2(DECAY_DIV).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_up  in  1  request F+1 this cycle.
- f_down  in  1  request F−1 this cycle.
- a_up  in  1  request A+1 this cycle.
- a_down  in  1  request A−1 this cycle.
- decay_en  in  1  enable the auto-decay mode.
- load  in  1  synchronous load of both setpoints.
- f_load  in  W  value loaded into F; clamped to [F_MIN, F_MAX].
- a_load  in  W  value loaded into A; clamped to [0, A_MAX].
- F  out  W  frequency setpoint (registered).
- A  out  W  amplitude setpoint (registered).
- F0  out  1  F == F_MIN.
- AF0  out  1  F0 and A == 0.
- f_lim  out  1  F == F_MAX.
- a_lim  out  1  A == A_MAX.
- state  out  2  current state: 0 RUN, 1 DECAY, 2 STOPPED.

## Operation
- **Reset (reset=0):** F=F_INIT, A=A_INIT, state=RUN, prescaler=0. Flags follow from these values (defaults: F0=0, AF0=0, f_lim=0, a_lim=0).
- **Priority:** load overrides all other requests in the same cycle. A clamped load value is not an error.
- **F update:**
  - f_up alone: F+1, saturating at F_MAX.
  - f_down alone: F−1, saturating at F_MIN.
  - f_up and f_down together: F holds.
- **A update:** dec = a_down OR tick, where tick is the decay pulse. Net change is a_up − dec.
  - a_up with a_down and/or tick: A holds.
  - a_down and tick together: a single decrement.
  - A saturates at 0 and at A_MAX.
- **Prescaler:**
  - Counts only in DECAY.
  - tick=1 when the prescaler equals DECAY_DIV−1; the prescaler then wraps to 0.
  - Cleared on load, on any a_up, and in every cycle the state is not DECAY.
- **State machine:**
  - RUN → DECAY when decay_en=1 and A≠0.
  - DECAY → RUN when decay_en=0. The prescaler clears.
  - DECAY → STOPPED in the cycle the A update makes A=0.
  - STOPPED → RUN on a_up, or on load with clamped a_load≠0.
  - STOPPED with decay_en still 1: remains in STOPPED; a_up or a nonzero load still exits to RUN.
  - F requests stay active in all states.
- **Flags:** combinational decodes of the registered F and A; no extra latency.

## Timing
- All outputs change only on a rising clk edge or on reset assertion.
- Request-to-output latency is 1 cycle: an input sampled at edge n is reflected in F/A/flags after edge n.
- First decay decrement occurs DECAY_DIV cycles after the edge that enters DECAY, then every DECAY_DIV cycles.
- DECAY_DIV=1: tick every cycle in DECAY.
- Reset asserted mid-operation: outputs go to reset values immediately. The first update happens at the first edge after deassertion.
- Inputs are synchronous to clk. Request inputs are level-sampled, one step per cycle held; edge detection belongs to the upstream decoder.

## Structure
- Shared package fa_pkg holds the state enum (RUN, DECAY, STOPPED) and its 2-bit encoding type.
- One sub-module: sat_updown, a W-bit saturating up/down register with load, clamp, and min/max parameters. It is instantiated twice, for F and for A.
- The prescaler and FSM live in the top level.

## Test plan
- Reset with defaults → F=5, A=5, state=RUN, F0=0, AF0=0. Releasing reset mid-stream with f_up held → first increment on the first edge after release.
- f_up held for 4 cycles → F=6, 7, 7, 7 with f_lim=1 from cycle 2. f_up and f_down together → F holds.
- load with f_load=7, a_load=7 under parameters A_MAX=6, F_MAX=6 → F=6, A=6. Simultaneous f_down → ignored.
- DECAY_DIV=4, A=2, decay_en=1 → A=1 after 4 cycles, then A=0 with state=STOPPED after 8 cycles. AF0=1 if F=F_MIN.
- In DECAY, a_down coincident with tick → A drops by 1 only. a_up coincident with tick → A unchanged and prescaler restarts.
- In STOPPED, a_up → A=1 and state=RUN. decay_en still 1 → DECAY on the next cycle.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared types for the frequency/amplitude setpoint unit.
//   fa_state_e : setpoint state machine encoding (2 bits)
package fa_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DECAY   = 2'd1,
        ST_STOPPED = 2'd2
    } fa_state_e;

    localparam int unsigned FA_STATE_W = 2;

endpackage

// File: rtl/fa_setpoint_sat_updown.sv
// Saturating up/down register with synchronous clamped load.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (q <- INIT)
//   load_i          load clamp(load_val_i) into q; overrides up/down
//   load_val_i      value to load
//   up_i, down_i    step +1 / -1; both together hold
//   q_o             registered value, always within [MIN, MAX]
module sat_updown #(
    parameter int unsigned W    = 3,
    parameter int unsigned MIN  = 0,
    parameter int unsigned MAX  = 7,
    parameter int unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] q_o
);

    localparam logic [W-1:0] MIN_V  = W'(MIN);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clamp compares use <= / >= so they stay meaningful when MIN is 0
    // or MAX is the all-ones value.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            if (load_val_i <= MIN_V) begin
                q_d = MIN_V;
            end else if (load_val_i >= MAX_V) begin
                q_d = MAX_V;
            end else begin
                q_d = load_val_i;
            end
        end else if (up_i && !down_i) begin
            if (q_q < MAX_V) q_d = q_q + W'(1);
        end else if (down_i && !up_i) begin
            if (q_q > MIN_V) q_d = q_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= INIT_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fa_setpoint.sv
// Frequency/amplitude setpoint unit for the rocking controller.
//
//   state   | meaning
//   RUN     | normal operation, A only moves on requests
//   DECAY   | auto-decay: A drops by 1 every DECAY_DIV cycles
//   STOPPED | A reached 0 while decaying; waits for a_up or nonzero load
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   f_up, f_down          F step requests (level, one step per cycle)
//   a_up, a_down          A step requests
//   decay_en              enable auto-decay
//   load, f_load, a_load  synchronous clamped load of both setpoints
//   F, A                  registered setpoints
//   F0, AF0, f_lim, a_lim decodes of F/A
//   state                 0 RUN, 1 DECAY, 2 STOPPED
module fa_setpoint
    import fa_pkg::*;
#(
    parameter int unsigned W         = 3,
    parameter int unsigned F_INIT    = 5,
    parameter int unsigned A_INIT    = 5,
    parameter int unsigned F_MIN     = 0,
    parameter int unsigned F_MAX     = 7,
    parameter int unsigned A_MAX     = 7,
    parameter int unsigned DECAY_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_up,
    input  logic                  f_down,
    input  logic                  a_up,
    input  logic                  a_down,
    input  logic                  decay_en,
    input  logic                  load,
    input  logic [W-1:0]          f_load,
    input  logic [W-1:0]          a_load,
    output logic [W-1:0]          F,
    output logic [W-1:0]          A,
    output logic                  F0,
    output logic                  AF0,
    output logic                  f_lim,
    output logic                  a_lim,
    output logic [FA_STATE_W-1:0] state
);

    // A one-bit prescaler still works for DECAY_DIV=1: it never leaves 0.
    localparam int unsigned   PW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_DIV - 1);

    fa_state_e     state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic          a_dec;
    logic          a_zero_d;

    assign tick  = (state_q == ST_DECAY) && (presc_q == PRESC_LAST);
    assign a_dec = a_down | tick;

    sat_updown #(
        .W    (W),
        .MIN  (F_MIN),
        .MAX  (F_MAX),
        .INIT (F_INIT)
    ) u_f (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (load),
        .load_val_i (f_load),
        .up_i       (f_up),
        .down_i     (f_down),
        .q_o        (F)
    );

    sat_updown #(
        .W    (W),
        .MIN  (0),
        .MAX  (A_MAX),
        .INIT (A_INIT)
    ) u_a (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (load),
        .load_val_i (a_load),
        .up_i       (a_up),
        .down_i     (a_dec),
        .q_o        (A)
    );

    // Predicts whether A will be 0 after this edge. The clamp to [0, A_MAX]
    // maps to 0 only when a_load itself is 0; a_up with a decrement holds A.
    always_comb begin
        a_zero_d = 1'b0;
        if (load) begin
            a_zero_d = (a_load == '0);
        end else if (a_up) begin
            a_zero_d = (A == '0) && a_dec;
        end else begin
            a_zero_d = (A == '0) || ((A == W'(1)) && a_dec);
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (load || a_up || (state_q != ST_DECAY) || tick) presc_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (decay_en && (A != '0)) state_q <= ST_DECAY;
                end
                ST_DECAY: begin
                    if (!decay_en)     state_q <= ST_RUN;
                    else if (a_zero_d) state_q <= ST_STOPPED;
                end
                ST_STOPPED: begin
                    if (a_up || (load && (a_load != '0))) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign state = state_q;
    assign F0    = (F == W'(F_MIN));
    assign AF0   = F0 && (A == '0);
    assign f_lim = (F == W'(F_MAX));
    assign a_lim = (A == W'(A_MAX));

endmodule

// File: tb/tb_fa_setpoint.sv
// Bench for fa_setpoint: two instances (default-like ranges with
// DECAY_DIV=4, and narrowed ranges with DECAY_DIV=1) share one stimulus.
// A behavioural model predicts each cycle's outputs into a queue; the
// entry is popped and compared after the clock edge.
module tb_fa_setpoint;

    typedef struct {
        int f;
        int a;
        int st;
        int presc;
    } mst_t;

    typedef struct {
        int fmin;
        int fmax;
        int amax;
        int div;
        int finit;
        int ainit;
    } prm_t;

    typedef struct {
        string       tag;
        logic [11:0] va;
        logic [11:0] vb;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       f_up = 1'b0, f_down = 1'b0, a_up = 1'b0, a_down = 1'b0;
    logic       decay_en = 1'b0, load = 1'b0;
    logic [2:0] f_load = '0, a_load = '0;

    logic [2:0] fa, aa, fb, ab;
    logic [1:0] sa, sb;
    logic       f0a, af0a, flima, alima;
    logic       f0b, af0b, flimb, alimb;

    int vectors = 0;
    int miscompares = 0;

    prm_t pa, pb;
    mst_t ma, mb;
    exp_t sb_q[$];

    fa_setpoint #(
        .W(3), .F_INIT(5), .A_INIT(5), .F_MIN(0), .F_MAX(7), .A_MAX(7), .DECAY_DIV(4)
    ) dut_a (
        .clk(clk), .reset(reset), .f_up(f_up), .f_down(f_down), .a_up(a_up),
        .a_down(a_down), .decay_en(decay_en), .load(load), .f_load(f_load),
        .a_load(a_load), .F(fa), .A(aa), .F0(f0a), .AF0(af0a), .f_lim(flima),
        .a_lim(alima), .state(sa)
    );

    fa_setpoint #(
        .W(3), .F_INIT(3), .A_INIT(4), .F_MIN(2), .F_MAX(6), .A_MAX(6), .DECAY_DIV(1)
    ) dut_b (
        .clk(clk), .reset(reset), .f_up(f_up), .f_down(f_down), .a_up(a_up),
        .a_down(a_down), .decay_en(decay_en), .load(load), .f_load(f_load),
        .a_load(a_load), .F(fb), .A(ab), .F0(f0b), .AF0(af0b), .f_lim(flimb),
        .a_lim(alimb), .state(sb)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic mst_t mreset(prm_t p);
        mst_t s;
        s.f = p.finit;
        s.a = p.ainit;
        s.st = 0;
        s.presc = 0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, prm_t p, bit fu, bit fd, bit au, bit ad,
                                   bit de, bit ld, int fl, int al);
        mst_t n = s;
        bit tick = (s.st == 1) && (s.presc == p.div - 1);
        if (ld) begin
            n.f = clampi(fl, p.fmin, p.fmax);
            n.a = clampi(al, 0, p.amax);
        end else begin
            if (fu && !fd)      n.f = clampi(s.f + 1, p.fmin, p.fmax);
            else if (fd && !fu) n.f = clampi(s.f - 1, p.fmin, p.fmax);
            n.a = clampi(s.a + int'(au) - int'(ad || tick), 0, p.amax);
        end
        n.presc = (ld || au || s.st != 1 || tick) ? 0 : s.presc + 1;
        case (s.st)
            0: if (de && s.a != 0) n.st = 1;
            1: begin
                if (!de)           n.st = 0;
                else if (n.a == 0) n.st = 2;
            end
            2: if (au || (ld && al != 0)) n.st = 0;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] expv(mst_t s, prm_t p);
        logic [2:0] f3 = 3'(s.f);
        logic [2:0] a3 = 3'(s.a);
        logic [1:0] s2 = 2'(s.st);
        logic       z  = (s.f == p.fmin);
        return {f3, a3, s2, z, z && (s.a == 0), s.f == p.fmax, s.a == p.amax};
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.va = expv(ma, pa);
        e.vb = expv(mb, pb);
        sb_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [11:0] oa, ob;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb_q.pop_front();
        oa = {fa, aa, sa, f0a, af0a, flima, alima};
        ob = {fb, ab, sb, f0b, af0b, flimb, alimb};
        vectors++;
        assert (oa === e.va) else begin
            miscompares++;
            $error("FAIL %s dut_a: observed %03h expected %03h", e.tag, oa, e.va);
        end
        vectors++;
        assert (ob === e.vb) else begin
            miscompares++;
            $error("FAIL %s dut_b: observed %03h expected %03h", e.tag, ob, e.vb);
        end
    endtask

    task automatic step(input string tag, input bit fu, input bit fd, input bit au,
                        input bit ad, input bit de, input bit ld, input int fl, input int al);
        @(negedge clk);
        f_up = fu; f_down = fd; a_up = au; a_down = ad;
        decay_en = de; load = ld; f_load = 3'(fl); a_load = 3'(al);
        ma = mstep(ma, pa, fu, fd, au, ad, de, ld, fl, al);
        mb = mstep(mb, pb, fu, fd, au, ad, de, ld, fl, al);
        push_exp(tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        pa = '{fmin: 0, fmax: 7, amax: 7, div: 4, finit: 5, ainit: 5};
        pb = '{fmin: 2, fmax: 6, amax: 6, div: 1, finit: 3, ainit: 4};
        ma = mreset(pa);
        mb = mreset(pb);

        #12;
        push_exp("reset");
        compare();

        // f_up held while reset is still asserted: nothing may move.
        @(negedge clk);
        f_up = 1'b1;
        @(posedge clk);
        #1;
        push_exp("reset_hold");
        compare();
        reset = 1'b1;

        step("f_up_first", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("f_up_sat", 1, 0, 0, 0, 0, 0, 0, 0);
        step("f_up_down", 1, 1, 0, 0, 0, 0, 0, 0);
        step("f_down", 0, 1, 0, 0, 0, 0, 0, 0);
        step("load_7", 0, 1, 0, 0, 0, 1, 7, 7);
        step("a_up_sat", 0, 0, 1, 0, 0, 0, 0, 0);
        step("load_0", 0, 0, 0, 0, 0, 1, 0, 0);
        step("f_down_sat", 0, 1, 0, 0, 0, 0, 0, 0);
        step("a_down_sat", 0, 0, 0, 1, 0, 0, 0, 0);
        step("a_up", 0, 0, 1, 0, 0, 0, 0, 0);
        step("a_up", 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) step("decay", 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("stopped_hold", 0, 0, 0, 0, 1, 0, 0, 0);
        step("stopped_a_up", 0, 0, 1, 0, 1, 0, 0, 0);
        step("redecay", 0, 0, 0, 0, 1, 0, 0, 0);
        step("load_in_decay", 0, 0, 0, 0, 1, 1, 2, 5);

        // Cycle 4 and 8 line up with dut_a's tick: a_down then a_up.
        for (int k = 1; k <= 12; k++) begin
            step("decay_mix", 0, 0, k == 8, k == 4, 1, 0, 0, 0);
        end
        step("decay_off", 0, 0, 0, 0, 0, 0, 0, 0);
        step("run_idle", 1, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle: outputs must return at once.
        @(negedge clk);
        reset = 1'b0;
        #1;
        ma = mreset(pa);
        mb = mreset(pb);
        push_exp("async_reset");
        compare();
        @(posedge clk);
        #1;
        push_exp("async_reset_hold");
        compare();
        reset = 1'b1;
        step("post_reset_a_up", 0, 0, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
